// File: rtl/writeback_stage.sv
// Writeback (W) stage: W pipeline register, load extraction, writeback mux,
// register-file write port, retired-instruction counter. Optional forwarding via WB_FWD_EN.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_o,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_E,
    input  logic             reg_wr_in,
    input  logic [4:0]       rd_E,
    input  logic [1:0]       wb_sel_E,
    input  logic [2:0]       funct3_E,
    input  logic [XLEN-1:0]  alu_out_E,
    input  logic [XLEN-1:0]  rdata_dm_E,
    input  logic [XLEN-1:0]  pc_E,
    input  logic [XLEN-1:0]  csr_rdata_E,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    output logic [4:0]       waddr,
    output logic [XLEN-1:0]  wdata,
    output logic             reg_wr_E,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [CNT_W-1:0] instret
);

    logic            valid_w_q,  valid_w_d;
    logic            reg_wr_w_q, reg_wr_w_d;
    logic [4:0]      rd_w_q,     rd_w_d;
    logic [1:0]      wb_sel_w_q, wb_sel_w_d;
    logic [2:0]      funct3_w_q, funct3_w_d;
    logic [XLEN-1:0] alu_w_q,    alu_w_d;
    logic [XLEN-1:0] dm_w_q,     dm_w_d;
    logic [XLEN-1:0] pc_w_q,     pc_w_d;
    logic [XLEN-1:0] csr_w_q,    csr_w_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic            load_en;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;

    assign load_en = !flush_i && !stall_i;

    // Flush clears only the qualifiers; data registers keep stale values.
    always_comb begin
        valid_w_d  = valid_w_q;
        reg_wr_w_d = reg_wr_w_q;
        rd_w_d     = rd_w_q;
        wb_sel_w_d = wb_sel_w_q;
        funct3_w_d = funct3_w_q;
        alu_w_d    = alu_w_q;
        dm_w_d     = dm_w_q;
        pc_w_d     = pc_w_q;
        csr_w_d    = csr_w_q;
        if (flush_i) begin
            valid_w_d  = 1'b0;
            reg_wr_w_d = 1'b0;
        end else if (!stall_i) begin
            valid_w_d  = valid_E;
            reg_wr_w_d = reg_wr_in;
            rd_w_d     = rd_E;
            wb_sel_w_d = wb_sel_E;
            funct3_w_d = funct3_E;
            alu_w_d    = alu_out_E;
            dm_w_d     = rdata_dm_E;
            pc_w_d     = pc_E;
            csr_w_d    = csr_rdata_E;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (load_en && valid_E) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_o) begin
        if (!rst_n) begin
            valid_w_q  <= 1'b0;
            reg_wr_w_q <= 1'b0;
            rd_w_q     <= '0;
            wb_sel_w_q <= '0;
            funct3_w_q <= '0;
            alu_w_q    <= '0;
            dm_w_q     <= '0;
            pc_w_q     <= '0;
            csr_w_q    <= '0;
            instret_q  <= '0;
        end else begin
            valid_w_q  <= valid_w_d;
            reg_wr_w_q <= reg_wr_w_d;
            rd_w_q     <= rd_w_d;
            wb_sel_w_q <= wb_sel_w_d;
            funct3_w_q <= funct3_w_d;
            alu_w_q    <= alu_w_d;
            dm_w_q     <= dm_w_d;
            pc_w_q     <= pc_w_d;
            csr_w_q    <= csr_w_d;
            instret_q  <= instret_d;
        end
    end

    // Misaligned halves ignore alu_w_q[0] rather than trapping.
    always_comb begin
        ld_byte = dm_w_q[7:0];
        case (alu_w_q[1:0])
            2'd0:    ld_byte = dm_w_q[7:0];
            2'd1:    ld_byte = dm_w_q[15:8];
            2'd2:    ld_byte = dm_w_q[23:16];
            default: ld_byte = dm_w_q[31:24];
        endcase
        ld_half = alu_w_q[1] ? dm_w_q[31:16] : dm_w_q[15:0];
    end

    always_comb begin
        load_val = dm_w_q;
        case (funct3_w_q)
            3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = dm_w_q;
        endcase
    end

    always_comb begin
        wdata = alu_w_q;
        case (wb_sel_w_q)
            2'd0:    wdata = alu_w_q;
            2'd1:    wdata = load_val;
            2'd2:    wdata = pc_w_q + XLEN'(4);
            default: wdata = csr_w_q;
        endcase
    end

    assign waddr    = rd_w_q;
    assign reg_wr_E = valid_w_q && reg_wr_w_q && (rd_w_q != 5'd0);
    assign instret  = instret_q;

`ifdef WB_FWD_EN
    assign fwd_a = reg_wr_E && (rd_w_q == rs1_E);
    assign fwd_b = reg_wr_E && (rd_w_q == rs2_E);
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs1_E, rs2_E};
    assign fwd_a      = 1'b0;
    assign fwd_b      = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage using a scoreboard of expected W outputs.
module tb_writeback_stage;

    logic        clk_o = 1'b0;
    logic        rst_n, stall_i, flush_i, valid_E, reg_wr_in;
    logic [4:0]  rd_E, rs1_E, rs2_E;
    logic [1:0]  wb_sel_E;
    logic [2:0]  funct3_E;
    logic [31:0] alu_out_E, rdata_dm_E, pc_E, csr_rdata_E;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_wr_E, fwd_a, fwd_b;
    logic [31:0] instret;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] ir;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_ir = '0;

    always #5 clk_o = ~clk_o;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk_o(clk_o), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_E(valid_E), .reg_wr_in(reg_wr_in), .rd_E(rd_E), .wb_sel_E(wb_sel_E),
        .funct3_E(funct3_E), .alu_out_E(alu_out_E), .rdata_dm_E(rdata_dm_E),
        .pc_E(pc_E), .csr_rdata_E(csr_rdata_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .waddr(waddr), .wdata(wdata), .reg_wr_E(reg_wr_E), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .instret(instret)
    );

    // Drive one valid instruction and record what W must show after the next edge.
    task automatic issue(input string nm, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] pc, input logic [31:0] csr,
                         input logic [31:0] exp_wd, input logic exp_we);
        exp_t e;
        valid_E = 1'b1; reg_wr_in = 1'b1; rd_E = rd; wb_sel_E = sel; funct3_E = f3;
        alu_out_E = alu; rdata_dm_E = dm; pc_E = pc; csr_rdata_E = csr;
        exp_ir = exp_ir + 32'd1;
        e.waddr = rd; e.wdata = exp_wd; e.we = exp_we; e.ir = exp_ir; e.name = nm;
        sb.push_back(e);
        @(posedge clk_o); #1;
    endtask

    task automatic go_idle();
        valid_E = 1'b0; reg_wr_in = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        @(posedge clk_o); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        valid_E = 1'b1; reg_wr_in = 1'b1; rd_E = 5'd7; wb_sel_E = 2'd3; funct3_E = 3'd2;
        alu_out_E = 32'hDEAD_BEEF; rdata_dm_E = 32'h1111_2222; pc_E = 32'h100;
        csr_rdata_E = 32'h5555_AAAA; rs1_E = 5'd0; rs2_E = 5'd0;
        repeat (2) @(posedge clk_o);
        #1;
        total++;
        if (reg_wr_E !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || instret !== 32'd0
            || fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
            bad++;
            $display("FAIL reset: we=%b waddr=%0d wdata=%h instret=%0d fwd=%b%b, required all 0",
                     reg_wr_E, waddr, wdata, instret, fwd_a, fwd_b);
        end
        valid_E = 1'b0; reg_wr_in = 1'b0; rst_n = 1'b1;
        @(posedge clk_o); #1;
        exp_ir = '0;
    endtask

    task automatic test_writeback_table();
        exp_t e;
        issue("alu", 5'd5, 2'd0, 3'd2, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
        issue("lb_1", 5'd1, 2'd1, 3'b000, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_007F, 1'b1);
        issue("lb_3", 5'd2, 2'd1, 3'b000, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b1);
        issue("lbu_3", 5'd3, 2'd1, 3'b100, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_0080, 1'b1);
        issue("lh_2", 5'd4, 2'd1, 3'b001, 32'h2, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b1);
        issue("lhu_0", 5'd6, 2'd1, 3'b101, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_7F01, 1'b1);
        issue("lw", 5'd8, 2'd1, 3'b010, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 32'h80FF_7F01, 1'b1);
        issue("lh_mis3", 5'd9, 2'd1, 3'b001, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b1);
        issue("f3_111", 5'd10, 2'd1, 3'b111, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0, 32'h80FF_7F01, 1'b1);
        issue("pc4_wrap", 5'd11, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        issue("pc4_x0", 5'd0, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
        issue("csr", 5'd31, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
        // Back-to-back operations with random ALU values at full rate.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            logic [4:0]  r;
            v = $urandom;
            r = 5'($urandom_range(1, 31));
            issue("b2b", r, 2'd0, 3'd0, v, ~v, v ^ 32'h55, 32'h0, v, 1'b1);
        end
        go_idle();
        // Issue is one cycle ahead of the pop, so the queue is drained here in order.
        while (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (e.name == "") begin
                bad++;
                $display("FAIL scoreboard_empty_name");
            end
        end
    endtask

    // Each issue is checked one cycle after being driven.
    task automatic test_latency();
        exp_t e;
        string nm;
        logic [31:0] vals [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFE};
        for (int i = 0; i < 4; i++) begin
            issue("lat_alu", 5'(12 + i), 2'd0, 3'd0, vals[i], 32'h0, 32'h0, 32'h0, vals[i], 1'b1);
            e = sb.pop_front();
            total++;
            if (waddr !== e.waddr || wdata !== e.wdata || reg_wr_E !== e.we || instret !== e.ir) begin
                bad++;
                $display("FAIL %s: waddr=%0d wdata=%h we=%b ir=%0d required waddr=%0d wdata=%h we=%b ir=%0d",
                         e.name, waddr, wdata, reg_wr_E, instret, e.waddr, e.wdata, e.we, e.ir);
            end
        end
        nm = "lat";
        go_idle();
        total++;
        if (reg_wr_E !== 1'b0 || instret !== exp_ir) begin
            bad++;
            $display("FAIL %s_idle: we=%b ir=%0d required we=0 ir=%0d", nm, reg_wr_E, instret, exp_ir);
        end
    endtask

    task automatic test_table_checked();
        exp_t e;
        logic [31:0] d;
        d = 32'h80FF_7F01;
        issue("alu", 5'd5, 2'd0, 3'd2, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
        e = sb.pop_front(); total++;
        if (waddr !== e.waddr || wdata !== e.wdata || reg_wr_E !== e.we || instret !== e.ir) begin
            bad++;
            $display("FAIL %s: waddr=%0d wdata=%h we=%b ir=%0d required waddr=%0d wdata=%h we=%b ir=%0d",
                     e.name, waddr, wdata, reg_wr_E, instret, e.waddr, e.wdata, e.we, e.ir);
        end
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:  issue("lb_1",    5'd1,  2'd1, 3'b000, 32'h1, d, 32'h0, 32'h0, 32'h0000_007F, 1'b1);
                1:  issue("lb_3",    5'd2,  2'd1, 3'b000, 32'h3, d, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b1);
                2:  issue("lbu_3",   5'd3,  2'd1, 3'b100, 32'h3, d, 32'h0, 32'h0, 32'h0000_0080, 1'b1);
                3:  issue("lh_2",    5'd4,  2'd1, 3'b001, 32'h2, d, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b1);
                4:  issue("lhu_0",   5'd6,  2'd1, 3'b101, 32'h0, d, 32'h0, 32'h0, 32'h0000_7F01, 1'b1);
                5:  issue("lw",      5'd8,  2'd1, 3'b010, 32'h0, d, 32'h0, 32'h0, d, 1'b1);
                6:  issue("lh_mis3", 5'd9,  2'd1, 3'b001, 32'h3, d, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b1);
                7:  issue("f3_111",  5'd10, 2'd1, 3'b111, 32'h1, d, 32'h0, 32'h0, d, 1'b1);
                8:  issue("pc4_wrap",5'd11, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
                9:  issue("pc4_x0",  5'd0,  2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
                default: issue("csr", 5'd31, 2'd3, 3'd0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
            endcase
            e = sb.pop_front(); total++;
            if (waddr !== e.waddr || wdata !== e.wdata || reg_wr_E !== e.we || instret !== e.ir) begin
                bad++;
                $display("FAIL %s: waddr=%0d wdata=%h we=%b ir=%0d required waddr=%0d wdata=%h we=%b ir=%0d",
                         e.name, waddr, wdata, reg_wr_E, instret, e.waddr, e.wdata, e.we, e.ir);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            logic [4:0]  r;
            v = $urandom;
            r = 5'($urandom_range(1, 31));
            issue("b2b", r, 2'd0, 3'd0, v, ~v, v ^ 32'h55, 32'h0, v, 1'b1);
            e = sb.pop_front(); total++;
            if (waddr !== e.waddr || wdata !== e.wdata || reg_wr_E !== e.we || instret !== e.ir) begin
                bad++;
                $display("FAIL %s: waddr=%0d wdata=%h we=%b ir=%0d required waddr=%0d wdata=%h we=%b ir=%0d",
                         e.name, waddr, wdata, reg_wr_E, instret, e.waddr, e.wdata, e.we, e.ir);
            end
        end
        go_idle();
    endtask

    task automatic test_stall_flush();
        exp_t e;
        issue("stall_A", 5'd9, 2'd0, 3'd0, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0, 32'hA5A5_0001, 1'b1);
        e = sb.pop_front(); total++;
        if (waddr !== e.waddr || wdata !== e.wdata || reg_wr_E !== e.we || instret !== e.ir) begin
            bad++;
            $display("FAIL stall_A: waddr=%0d wdata=%h we=%b ir=%0d required waddr=%0d wdata=%h we=%b ir=%0d",
                     waddr, wdata, reg_wr_E, instret, e.waddr, e.wdata, e.we, e.ir);
        end
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_E = 5'(20 + i); alu_out_E = 32'h1000 + 32'(i); wb_sel_E = 2'd3; valid_E = 1'b1;
            @(posedge clk_o); #1;
            total++;
            if (waddr !== 5'd9 || wdata !== 32'hA5A5_0001 || reg_wr_E !== 1'b1 || instret !== exp_ir) begin
                bad++;
                $display("FAIL stall_hold%0d: waddr=%0d wdata=%h we=%b ir=%0d required waddr=9 wdata=a5a50001 we=1 ir=%0d",
                         i, waddr, wdata, reg_wr_E, instret, exp_ir);
            end
        end
        flush_i = 1'b1;
        @(posedge clk_o); #1;
        total++;
        if (reg_wr_E !== 1'b0 || instret !== exp_ir) begin
            bad++;
            $display("FAIL flush_stall: we=%b ir=%0d required we=0 ir=%0d", reg_wr_E, instret, exp_ir);
        end
        stall_i = 1'b0;
        @(posedge clk_o); #1;
        total++;
        if (reg_wr_E !== 1'b0 || instret !== exp_ir) begin
            bad++;
            $display("FAIL flush_only: we=%b ir=%0d required we=0 ir=%0d", reg_wr_E, instret, exp_ir);
        end
        go_idle();
    endtask

    task automatic test_forwarding();
        logic exp_a;
        issue("fwd_w", 5'd7, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h0, 32'h77, 1'b1);
        void'(sb.pop_front());
        valid_E = 1'b0; rs1_E = 5'd7; rs2_E = 5'd3; #1;
`ifdef WB_FWD_EN
        exp_a = 1'b1;
`else
        exp_a = 1'b0;
`endif
        total++;
        if (fwd_a !== exp_a || fwd_b !== 1'b0) begin
            bad++;
            $display("FAIL fwd_rd7: fwd_a=%b fwd_b=%b required fwd_a=%b fwd_b=0", fwd_a, fwd_b, exp_a);
        end
        issue("fwd_x0", 5'd0, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h0, 32'h99, 1'b0);
        void'(sb.pop_front());
        valid_E = 1'b0; rs1_E = 5'd0; rs2_E = 5'd0; #1;
        total++;
        if (fwd_a !== 1'b0 || fwd_b !== 1'b0) begin
            bad++;
            $display("FAIL fwd_x0: fwd_a=%b fwd_b=%b required 0 0", fwd_a, fwd_b);
        end
        go_idle();
    endtask

    task automatic test_reset_priority();
        issue("pre_rst", 5'd13, 2'd0, 3'd0, 32'h1313, 32'h0, 32'h0, 32'h0, 32'h1313, 1'b1);
        void'(sb.pop_front());
        stall_i = 1'b1; flush_i = 1'b1; rst_n = 1'b0;
        @(posedge clk_o); #1;
        total++;
        if (reg_wr_E !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL rst_priority: we=%b waddr=%0d wdata=%h ir=%0d required all 0",
                     reg_wr_E, waddr, wdata, instret);
        end
        rst_n = 1'b1;
        exp_ir = '0;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_table_checked();
        test_back_to_back();
        test_stall_flush();
        test_forwarding();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units, required completion");
        $fatal(1);
    end

endmodule
